// File: rtl/imem_stall_responder.sv
// Multi-cycle word memory responder: holds each accepted request for LATENCY cycles,
// stalls the requester meanwhile, and completes with a one-cycle Done pulse.
module imem_stall_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [3:0]             cnt_r, cnt_nxt_s;
    logic [ADDR_BITS-1:0]   idx_r, idx_nxt_s;
    logic [15:0]            data_r, data_nxt_s;
    logic                   op_wr_r, op_wr_nxt_s;
    logic [15:0]            mem_r [DEPTH];

    logic                   legal_s;
    logic                   accept_s;
    logic                   done_s;
    logic                   unused_addr_s;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign unused_addr_s = ^(Addr >> (ADDR_BITS + 1));

    // Request qualification and completion detection; reset overrides everything.
    always_comb begin
        legal_s  = (Rd ^ Wr) & ~Addr[0];
        accept_s = 1'b0;
        done_s   = 1'b0;
        if (rst) begin
            accept_s = 1'b0;
            done_s   = 1'b0;
        end else begin
            accept_s = (state_r == IDLE) & legal_s;
            done_s   = (state_r == BUSY) & (cnt_r == 4'd0);
        end
    end

    // Next-state logic for the control FSM and request latches.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        data_nxt_s  = data_r;
        op_wr_nxt_s = op_wr_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = LOAD_CNT;
                    idx_nxt_s   = Addr[ADDR_BITS:1];
                    data_nxt_s  = DataIn;
                    op_wr_nxt_s = Wr;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control FSM and request latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            data_r  <= 16'h0000;
            op_wr_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            data_r  <= data_nxt_s;
            op_wr_r <= op_wr_nxt_s;
        end
    end

    // Storage array; a write commits only at the closing edge of its Done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (done_s && op_wr_r) begin
            mem_r[idx_r] <= data_r;
        end
    end

    // Requester-facing outputs; Stall and Err react to the request in its own cycle.
    always_comb begin
        DataOut = 16'h0000;
        Done    = 1'b0;
        Stall   = 1'b0;
        Err     = 1'b0;
        if (rst) begin
            Stall = 1'b0;
        end else if (state_r == BUSY) begin
            Done  = done_s;
            Stall = ~done_s;
            if (done_s && !op_wr_r) begin
                DataOut = mem_r[idx_r];
            end else begin
                DataOut = 16'h0000;
            end
        end else begin
            Stall = accept_s;
            Err   = (Rd | Wr) & ~legal_s;
        end
    end

endmodule

// File: tb/tb_imem_stall_responder.sv
// Directed bench: LATENCY=4 instance for the main scenarios, LATENCY=1 instance for back-to-back.
module tb_imem_stall_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr, din, dout;
    logic        rd, wr, done, stall, err;
    logic [15:0] addr1, din1, dout1;
    logic        rd1, wr1, done1, stall1, err1;

    int total;
    int bad;

    imem_stall_responder #(.LATENCY(4), .ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
        .DataOut(dout), .Done(done), .Stall(stall), .Err(err)
    );

    imem_stall_responder #(.LATENCY(1), .ADDR_BITS(10)) dut1 (
        .clk(clk), .rst(rst), .Addr(addr1), .DataIn(din1), .Rd(rd1), .Wr(wr1),
        .DataOut(dout1), .Done(done1), .Stall(stall1), .Err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sample {DataOut,Done,Stall,Err} of the LATENCY=4 instance mid-cycle, then move to the next cycle.
    task automatic cyc(input string tag, input logic [15:0] d, input logic dn, input logic st, input logic er);
        @(negedge clk);
        check(tag, {13'd0, dout, done, stall, err}, {13'd0, d, dn, st, er});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1(input string tag, input logic [15:0] d, input logic dn, input logic st, input logic er);
        @(negedge clk);
        check(tag, {13'd0, dout1, done1, stall1, err1}, {13'd0, d, dn, st, er});
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rd = r; wr = w; addr = a; din = d;
    endtask

    // Full LATENCY=4 transaction: 4 stall cycles, then the Done cycle with the given data.
    task automatic run_req(input string tag, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_d);
        set_req(r, w, a, d);
        for (int i = 0; i < 4; i++) cyc({tag, "_stall"}, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc({tag, "_done"}, exp_d, 1'b1, 1'b0, 1'b0);
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0000; din1 = 16'h0000;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reset / idle
        for (int i = 0; i < 3; i++) cyc("idle", 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc1("idle_l1", 16'h0000, 1'b0, 1'b0, 1'b0);
        run_req("rd_reset_mem", 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);

        // Write then read
        run_req("wr_beef", 1'b0, 1'b1, 16'h0004, 16'hBEEF, 16'h0000);
        run_req("rd_beef", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'hBEEF);

        // Illegal requests
        set_req(1'b1, 1'b0, 16'h0003, 16'h0000);
        cyc("err_odd", 16'h0000, 1'b0, 1'b0, 1'b1);
        set_req(1'b1, 1'b1, 16'h0004, 16'h5555);
        cyc("err_both", 16'h0000, 1'b0, 1'b0, 1'b1);
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) cyc("err_no_done", 16'h0000, 1'b0, 1'b0, 1'b0);
        run_req("rd_after_err", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'hBEEF);

        // Input churn while BUSY
        set_req(1'b1, 1'b0, 16'h0004, 16'h0000);
        cyc("churn_accept", 16'h0000, 1'b0, 1'b1, 1'b0);
        set_req(1'b1, 1'b1, 16'h0008, 16'hAAAA);
        for (int i = 0; i < 3; i++) cyc("churn_stall", 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc("churn_done", 16'hBEEF, 1'b1, 1'b0, 1'b0);
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        run_req("rd_w8", 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0000);

        // Reset mid-request
        set_req(1'b0, 1'b1, 16'h0006, 16'h1234);
        cyc("rstmid_t0", 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc("rstmid_t1", 16'h0000, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
        cyc("rstmid_t2", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc("rstmid_no_done", 16'h0000, 1'b0, 1'b0, 1'b0);
        run_req("rd_w6_after_rst", 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h0000);
        run_req("rd_w4_after_rst", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000);

        // LATENCY=1: aliased write, then back-to-back reads with Rd held high
        wr1 = 1'b1; addr1 = 16'h0802; din1 = 16'hC0DE;
        cyc1("l1_wr_stall", 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc1("l1_wr_done", 16'h0000, 1'b1, 1'b0, 1'b0);
        wr1 = 1'b0; rd1 = 1'b1; addr1 = 16'h0002; din1 = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            cyc1("l1_b2b_stall", 16'h0000, 1'b0, 1'b1, 1'b0);
            cyc1("l1_b2b_done", 16'hC0DE, 1'b1, 1'b0, 1'b0);
        end
        rd1 = 1'b0;
        cyc1("l1_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
